spdif_block_sequencer: RTL and testbench

Sequences the subframe dismantler. Takes preamble strobes from the preamble detector and the payload bit stream, and tracks block, frame and channel position. It forwards exactly 28 payload bits per subframe to the dismantler with `frame_counter` and `in_channel` aligned to them. It holds the dismantler in reset while out of lock and resynchronises on any framing error, timeout or `kill` from the dismantler.

---
 rtl/spdif_block_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_spdif_block_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_block_sequencer.sv
// S/PDIF block sequencer: tracks block/frame/channel position from preamble strobes,
// gates 28 payload bits per subframe to the dismantler, and resynchronises on any framing loss.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_HUNT       | out of lock, dismantler held in reset, waiting for a B preamble
// S_PAYLOAD    | locked, forwarding payload bits, bit_cnt 0..27
// S_EXPECT_PRE | locked, all 28 bits received, next preamble due
module spdif_block_sequencer #(
  parameter int FRAMES_PER_BLOCK  = 192,
  parameter int BITS_PER_SUBFRAME = 28,
  parameter int TIMEOUT           = 1024,
  parameter int ERR_W             = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pre_v,
  input  logic [1:0]       i_pre_type,
  input  logic             i_vin,
  input  logic             i_din,
  input  logic             i_kill,
  input  logic             i_done,
  output logic             o_vout,
  output logic             o_dout,
  output logic [7:0]       o_frame_counter,
  output logic             o_in_channel,
  output logic             o_dis_rst,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_sync_err_count,
  output logic [15:0]      o_block_count
);

  localparam logic [1:0] PRE_B = 2'd0;
  localparam logic [1:0] PRE_M = 2'd1;
  localparam logic [1:0] PRE_W = 2'd2;

  localparam int BIT_W  = $clog2(BITS_PER_SUBFRAME);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(BITS_PER_SUBFRAME - 1);
  localparam logic [7:0]        LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_PAYLOAD,
    S_EXPECT_PRE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BIT_W-1:0]   w_bit_cnt_nxt;
  logic [7:0]         r_frame_counter;
  logic [7:0]         w_fc_nxt;
  logic               r_in_channel;
  logic               w_ch_nxt;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [IDLE_W-1:0]  w_idle_nxt;
  logic               r_vout;
  logic               r_dout;
  logic               r_dis_rst;
  logic               r_locked;
  logic               r_err_pulse;
  logic [ERR_W-1:0]   r_sync_err_count;
  logic [15:0]        r_block_count;

  logic               w_fwd;
  logic               w_sync_err;
  logic               w_idle;
  logic               w_timeout;
  logic [1:0]         w_pre_exp;

  assign w_idle    = !i_vin && !i_pre_v;
  assign w_timeout = w_idle && (r_idle_cnt == IDLE_LAST);
  assign w_pre_exp = !r_in_channel ? PRE_W :
                     (r_frame_counter == LAST_FRAME) ? PRE_B : PRE_M;

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_fc_nxt      = r_frame_counter;
    w_ch_nxt      = r_in_channel;
    w_fwd         = 1'b0;
    w_sync_err    = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (i_pre_v && i_pre_type == PRE_B) begin
          w_state_nxt   = S_PAYLOAD;
          w_bit_cnt_nxt = '0;
          w_fc_nxt      = '0;
          w_ch_nxt      = 1'b0;
        end
      end
      S_PAYLOAD: begin
        if (i_kill || w_timeout || i_pre_v) begin
          w_sync_err = 1'b1;
        end else if (i_vin) begin
          w_fwd = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt   = S_EXPECT_PRE;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      S_EXPECT_PRE: begin
        if (i_kill || w_timeout) begin
          w_sync_err = 1'b1;
        end else if (i_pre_v) begin
          // a coincident vin is dropped; the preamble alone decides
          if (i_pre_type == w_pre_exp) begin
            w_state_nxt   = S_PAYLOAD;
            w_bit_cnt_nxt = '0;
            case (i_pre_type)
              PRE_W: w_ch_nxt = 1'b1;
              PRE_M: begin
                w_ch_nxt = 1'b0;
                w_fc_nxt = r_frame_counter + 8'd1;
              end
              default: begin
                w_ch_nxt = 1'b0;
                w_fc_nxt = '0;
              end
            endcase
          end else begin
            w_sync_err = 1'b1;
          end
        end else if (i_vin) begin
          w_sync_err = 1'b1;
        end
      end
      default: w_state_nxt = S_HUNT;
    endcase
    if (w_sync_err) w_state_nxt = S_HUNT;
  end

  always_comb begin
    w_idle_nxt = r_idle_cnt + IDLE_W'(1);
    if (r_state == S_HUNT || w_state_nxt == S_HUNT || !w_idle) w_idle_nxt = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_HUNT;
      r_bit_cnt        <= '0;
      r_frame_counter  <= '0;
      r_in_channel     <= 1'b0;
      r_idle_cnt       <= '0;
      r_vout           <= 1'b0;
      r_dout           <= 1'b0;
      r_dis_rst        <= 1'b1;
      r_locked         <= 1'b0;
      r_err_pulse      <= 1'b0;
      r_sync_err_count <= '0;
      r_block_count    <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_frame_counter <= w_fc_nxt;
      r_in_channel    <= w_ch_nxt;
      r_idle_cnt      <= w_idle_nxt;
      r_vout          <= w_fwd;
      r_dout          <= w_fwd & i_din;
      r_dis_rst       <= (w_state_nxt == S_HUNT);
      r_locked        <= (w_state_nxt != S_HUNT);
      r_err_pulse     <= w_sync_err;
      if (w_sync_err && r_sync_err_count != {ERR_W{1'b1}})
        r_sync_err_count <= r_sync_err_count + ERR_W'(1);
      if (i_done) r_block_count <= r_block_count + 16'd1;
    end
  end

  assign o_vout           = r_vout;
  assign o_dout           = r_dout;
  assign o_frame_counter  = r_frame_counter;
  assign o_in_channel     = r_in_channel;
  assign o_dis_rst        = r_dis_rst;
  assign o_locked         = r_locked;
  assign o_err_pulse      = r_err_pulse;
  assign o_sync_err_count = r_sync_err_count;
  assign o_block_count    = r_block_count;

endmodule

// File: tb/tb_spdif_block_sequencer.sv
// Bench for spdif_block_sequencer: forwarded bits are checked against a scoreboard of
// expected {dout, frame_counter, in_channel}; framing/lock behaviour is checked inline per scenario.
module tb_spdif_block_sequencer;

  localparam logic [1:0] PB = 2'd0;
  localparam logic [1:0] PM = 2'd1;
  localparam logic [1:0] PW = 2'd2;
  localparam logic [1:0] PX = 2'd3;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_pre_v = 1'b0;
  logic [1:0]  i_pre_type = 2'd0;
  logic        i_vin = 1'b0;
  logic        i_din = 1'b0;
  logic        i_kill = 1'b0;
  logic        i_done = 1'b0;
  logic        o_vout, o_dout, o_in_channel, o_dis_rst, o_locked, o_err_pulse;
  logic [7:0]  o_frame_counter;
  logic [15:0] o_sync_err_count;
  logic [15:0] o_block_count;

  spdif_block_sequencer dut (
    .i_clk(clk), .i_rst(i_rst), .i_pre_v(i_pre_v), .i_pre_type(i_pre_type),
    .i_vin(i_vin), .i_din(i_din), .i_kill(i_kill), .i_done(i_done),
    .o_vout(o_vout), .o_dout(o_dout), .o_frame_counter(o_frame_counter),
    .o_in_channel(o_in_channel), .o_dis_rst(o_dis_rst), .o_locked(o_locked),
    .o_err_pulse(o_err_pulse), .o_sync_err_count(o_sync_err_count),
    .o_block_count(o_block_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d;
    logic [7:0] fc;
    logic       ch;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_miss = 0;
  int         n_vout = 0;
  int         n_errp = 0;
  logic [7:0] m_fc = 8'd0;
  logic       m_ch = 1'b0;

  always @(negedge clk) begin
    if (o_err_pulse === 1'b1) n_errp = n_errp + 1;
    if (o_vout === 1'b1) begin
      n_vout = n_vout + 1;
      n_vec = n_vec + 1;
      if (sb.size() == 0) begin
        n_miss = n_miss + 1;
        $display("FAIL unexpected_vout: got vout=1 fc=%0d ch=%0d, required no forwarded bit", o_frame_counter, o_in_channel);
      end else begin
        mon_e = sb.pop_front();
        if ({o_dout, o_frame_counter, o_in_channel} !== {mon_e.d, mon_e.fc, mon_e.ch}) begin
          n_miss = n_miss + 1;
          $display("FAIL fwd_bit: got dout=%b fc=%0d ch=%b, required dout=%b fc=%0d ch=%b",
                   o_dout, o_frame_counter, o_in_channel, mon_e.d, mon_e.fc, mon_e.ch);
        end
      end
      n_vec = n_vec + 1;
      if (o_dis_rst !== 1'b0) begin
        n_miss = n_miss + 1;
        $display("FAIL vout_in_dis_rst: got dis_rst=%b with vout=1, required 0", o_dis_rst);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic send_pre(input logic [1:0] t);
    i_pre_v = 1'b1;
    i_pre_type = t;
    tick();
    i_pre_v = 1'b0;
  endtask

  // fwd=1: the bit is expected at the dismantler with the model's frame/channel
  task automatic send_bits(input int n, input logic fwd, input int gap_max);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      i_vin = 1'b1;
      i_din = 1'($urandom_range(0, 1));
      if (fwd) begin
        e.d = i_din; e.fc = m_fc; e.ch = m_ch;
        sb.push_back(e);
      end
      tick();
      i_vin = 1'b0;
      i_din = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if ({o_vout, o_dout, o_in_channel, o_dis_rst, o_locked, o_err_pulse} !== 6'b000100) begin n_miss++; $display("FAIL reset_ctrl: got %b, required 000100", {o_vout, o_dout, o_in_channel, o_dis_rst, o_locked, o_err_pulse}); end
    n_vec++; if (o_frame_counter !== 8'd0) begin n_miss++; $display("FAIL reset_fc: got %0d, required 0", o_frame_counter); end
    n_vec++; if (o_sync_err_count !== 16'd0) begin n_miss++; $display("FAIL reset_errcnt: got %0d, required 0", o_sync_err_count); end
    n_vec++; if (o_block_count !== 16'd0) begin n_miss++; $display("FAIL reset_blkcnt: got %0d, required 0", o_block_count); end
  endtask

  task automatic test_lock();
    int e0, v0;
    do_reset();
    e0 = n_errp; v0 = n_vout;
    send_pre(PM);
    send_pre(PX);
    n_vec++; if (o_dis_rst !== 1'b1) begin n_miss++; $display("FAIL lock_pre_hunt: got dis_rst=%b, required 1", o_dis_rst); end
    send_pre(PB);
    n_vec++; if ({o_dis_rst, o_locked} !== 2'b01) begin n_miss++; $display("FAIL lock_after_b: got dis_rst,locked=%b, required 01", {o_dis_rst, o_locked}); end
    n_vec++; if ({o_frame_counter, o_in_channel} !== 9'd0) begin n_miss++; $display("FAIL lock_pos_a: got fc=%0d ch=%b, required 0 0", o_frame_counter, o_in_channel); end
    m_fc = 8'd0; m_ch = 1'b0;
    send_bits(28, 1'b1, 1);
    send_pre(PW);
    n_vec++; if ({o_frame_counter, o_in_channel} !== {8'd0, 1'b1}) begin n_miss++; $display("FAIL lock_pos_b: got fc=%0d ch=%b, required 0 1", o_frame_counter, o_in_channel); end
    m_ch = 1'b1;
    send_bits(28, 1'b1, 1);
    tick();
    n_vec++; if (n_vout - v0 !== 56) begin n_miss++; $display("FAIL lock_vout_count: got %0d, required 56", n_vout - v0); end
    n_vec++; if (n_errp - e0 !== 0) begin n_miss++; $display("FAIL lock_err_pulses: got %0d, required 0", n_errp - e0); end
  endtask

  task automatic test_full_block();
    do_reset();
    send_pre(PB);
    for (int f = 0; f < 192; f++) begin
      if (f > 0) send_pre(PM);
      m_fc = 8'(f); m_ch = 1'b0;
      send_bits(28, 1'b1, 0);
      if (f == 100) i_done = 1'b1;
      send_pre(PW);
      i_done = 1'b0;
      m_ch = 1'b1;
      send_bits(28, 1'b1, 0);
    end
    n_vec++; if ({o_frame_counter, o_in_channel} !== {8'd191, 1'b1}) begin n_miss++; $display("FAIL block_end_pos: got fc=%0d ch=%b, required 191 1", o_frame_counter, o_in_channel); end
    send_pre(PB);
    n_vec++; if ({o_frame_counter, o_in_channel, o_locked} !== {8'd0, 1'b0, 1'b1}) begin n_miss++; $display("FAIL block_wrap: got fc=%0d ch=%b locked=%b, required 0 0 1", o_frame_counter, o_in_channel, o_locked); end
    n_vec++; if (o_block_count !== 16'd1) begin n_miss++; $display("FAIL block_count: got %0d, required 1", o_block_count); end
    n_vec++; if (o_sync_err_count !== 16'd0) begin n_miss++; $display("FAIL block_errcnt: got %0d, required 0", o_sync_err_count); end
  endtask

  task automatic test_short();
    int e0;
    do_reset();
    e0 = n_errp;
    send_pre(PB);
    m_fc = 8'd0; m_ch = 1'b0;
    send_bits(20, 1'b1, 0);
    send_pre(PW);
    n_vec++; if ({o_err_pulse, o_dis_rst, o_locked} !== 3'b110) begin n_miss++; $display("FAIL short_err: got err,dis_rst,locked=%b, required 110", {o_err_pulse, o_dis_rst, o_locked}); end
    n_vec++; if (o_sync_err_count !== 16'd1) begin n_miss++; $display("FAIL short_errcnt: got %0d, required 1", o_sync_err_count); end
    tick();
    n_vec++; if (o_err_pulse !== 1'b0) begin n_miss++; $display("FAIL short_pulse_width: got %b, required 0", o_err_pulse); end
    send_pre(PM);
    send_bits(28, 1'b0, 0);
    n_vec++; if ({o_dis_rst, o_locked} !== 2'b10) begin n_miss++; $display("FAIL short_m_ignored: got dis_rst,locked=%b, required 10", {o_dis_rst, o_locked}); end
    send_pre(PB);
    n_vec++; if ({o_locked, o_frame_counter, o_in_channel} !== {1'b1, 8'd0, 1'b0}) begin n_miss++; $display("FAIL short_relock: got locked=%b fc=%0d ch=%b, required 1 0 0", o_locked, o_frame_counter, o_in_channel); end
    send_bits(28, 1'b1, 0);
    tick();
    n_vec++; if (n_errp - e0 !== 1) begin n_miss++; $display("FAIL short_pulses: got %0d, required 1", n_errp - e0); end
  endtask

  task automatic test_wrong_pre();
    do_reset();
    send_pre(PB);
    for (int f = 0; f < 192; f++) begin
      if (f > 0) send_pre(PM);
      m_fc = 8'(f); m_ch = 1'b0;
      send_bits(28, 1'b1, 0);
      send_pre(PW);
      m_ch = 1'b1;
      send_bits(28, 1'b1, 0);
    end
    send_pre(PM);
    n_vec++; if ({o_err_pulse, o_locked} !== 2'b10) begin n_miss++; $display("FAIL wrong_m_at_191: got err,locked=%b, required 10", {o_err_pulse, o_locked}); end
    n_vec++; if (o_sync_err_count !== 16'd1) begin n_miss++; $display("FAIL wrong_m_errcnt: got %0d, required 1", o_sync_err_count); end
    send_pre(PB);
    for (int f = 0; f <= 5; f++) begin
      if (f > 0) send_pre(PM);
      m_fc = 8'(f); m_ch = 1'b0;
      send_bits(28, 1'b1, 0);
      if (f < 5) begin
        send_pre(PW);
        m_ch = 1'b1;
        send_bits(28, 1'b1, 0);
      end
    end
    n_vec++; if (o_frame_counter !== 8'd5) begin n_miss++; $display("FAIL wrong_b_pos: got fc=%0d, required 5", o_frame_counter); end
    send_pre(PB);
    n_vec++; if ({o_err_pulse, o_locked} !== 2'b10) begin n_miss++; $display("FAIL wrong_b_at_5: got err,locked=%b, required 10", {o_err_pulse, o_locked}); end
    n_vec++; if (o_sync_err_count !== 16'd2) begin n_miss++; $display("FAIL wrong_b_errcnt: got %0d, required 2", o_sync_err_count); end
    send_bits(28, 1'b0, 0);
    n_vec++; if ({o_dis_rst, o_locked} !== 2'b10) begin n_miss++; $display("FAIL wrong_b_not_reused: got dis_rst,locked=%b, required 10", {o_dis_rst, o_locked}); end
  endtask

  task automatic test_kill_timeout();
    int c;
    do_reset();
    send_pre(PB);
    m_fc = 8'd0; m_ch = 1'b0;
    send_bits(10, 1'b1, 0);
    i_kill = 1'b1; i_done = 1'b1; i_vin = 1'b1; i_din = 1'b1;
    tick();
    i_kill = 1'b0; i_done = 1'b0; i_vin = 1'b0; i_din = 1'b0;
    n_vec++; if ({o_err_pulse, o_dis_rst, o_locked, o_vout} !== 4'b1100) begin n_miss++; $display("FAIL kill_hunt: got err,dis_rst,locked,vout=%b, required 1100", {o_err_pulse, o_dis_rst, o_locked, o_vout}); end
    n_vec++; if ({o_sync_err_count, o_block_count} !== {16'd1, 16'd1}) begin n_miss++; $display("FAIL kill_counts: got err=%0d blk=%0d, required 1 1", o_sync_err_count, o_block_count); end
    send_bits(10, 1'b0, 0);
    send_pre(PB);
    send_bits(28, 1'b1, 0);
    i_kill = 1'b1;
    send_pre(PW);
    i_kill = 1'b0;
    n_vec++; if ({o_locked, o_sync_err_count} !== {1'b0, 16'd2}) begin n_miss++; $display("FAIL kill_beats_pre: got locked=%b errcnt=%0d, required 0 2", o_locked, o_sync_err_count); end
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    n_vec++; if ({o_err_pulse, o_sync_err_count} !== {1'b0, 16'd2}) begin n_miss++; $display("FAIL kill_in_hunt: got err=%b errcnt=%0d, required 0 2", o_err_pulse, o_sync_err_count); end
    send_pre(PB);
    c = 0;
    while (o_err_pulse !== 1'b1 && c < 1200) begin
      tick();
      c++;
    end
    n_vec++; if (c < 1024 || c > 1025) begin n_miss++; $display("FAIL timeout_cycles: got %0d idle cycles, required 1024..1025", c); end
    n_vec++; if ({o_locked, o_sync_err_count} !== {1'b0, 16'd3}) begin n_miss++; $display("FAIL timeout_state: got locked=%b errcnt=%0d, required 0 3", o_locked, o_sync_err_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_pre(PB);
    send_pre(PW);
    n_vec++; if ({o_err_pulse, o_sync_err_count} !== {1'b1, 16'd1}) begin n_miss++; $display("FAIL rstmid_setup_err: got err=%b errcnt=%0d, required 1 1", o_err_pulse, o_sync_err_count); end
    send_pre(PB);
    m_fc = 8'd0; m_ch = 1'b0;
    send_bits(28, 1'b1, 0);
    send_pre(PW);
    m_ch = 1'b1;
    send_bits(10, 1'b1, 0);
    i_rst = 1'b1; i_vin = 1'b1; i_din = 1'b1;
    tick();
    i_rst = 1'b0; i_vin = 1'b0; i_din = 1'b0;
    n_vec++; if ({o_vout, o_dout, o_in_channel, o_dis_rst, o_locked, o_err_pulse} !== 6'b000100) begin n_miss++; $display("FAIL rstmid_ctrl: got %b, required 000100", {o_vout, o_dout, o_in_channel, o_dis_rst, o_locked, o_err_pulse}); end
    n_vec++; if ({o_frame_counter, o_sync_err_count} !== 24'd0) begin n_miss++; $display("FAIL rstmid_counts: got fc=%0d errcnt=%0d, required 0 0", o_frame_counter, o_sync_err_count); end
    send_bits(18, 1'b0, 0);
    send_pre(PB);
    n_vec++; if ({o_locked, o_frame_counter, o_in_channel} !== {1'b1, 8'd0, 1'b0}) begin n_miss++; $display("FAIL rstmid_relock: got locked=%b fc=%0d ch=%b, required 1 0 0", o_locked, o_frame_counter, o_in_channel); end
    m_fc = 8'd0; m_ch = 1'b0;
    send_bits(28, 1'b1, 1);
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_lock();
    test_full_block();
    test_short();
    test_wrong_pre();
    test_kill_timeout();
    test_reset_mid();
    tick();
    n_vec++; if (sb.size() != 0) begin n_miss++; $display("FAIL scoreboard_drain: got %0d bits never forwarded, required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
